// File: rtl/toi2s_spdif_tx.sv
// S/PDIF (IEC 60958) biphase-mark transmitter: 24-bit stereo pairs in, serial subframes out.
// Build option TOI2S_SPDIF_CS_EN adds consumer channel-status on the C bit (otherwise C=0).
module toi2s_spdif_tx #(
  parameter int unsigned UI_DIV = 4,
  parameter logic [3:0]  CS_FS  = 4'b0100
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        ena,
  input  logic [23:0] sample_l,
  input  logic [23:0] sample_r,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        tx_out,
  output logic        block_start,
  output logic        underrun
);
  localparam int unsigned   CW      = $clog2(UI_DIV);
  localparam logic [CW-1:0] DIV_MAX = CW'(UI_DIV - 1);

  logic [CW-1:0] div_q, div_d;
  logic          ui_q, ui_d;
  logic [4:0]    slot_q, slot_d;
  logic          sub_q, sub_d;
  logic [7:0]    frame_q, frame_d;
  logic          full_q, full_d;
  logic [23:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [23:0]   tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  logic          tx_v_q, tx_v_d;
  logic          pre_inv_q, pre_inv_d;
  logic          tx_out_q, tx_out_d;
  logic          ready_q, ready_d;
  logic          bs_q, bs_d;
  logic          ur_q, ur_d;

  logic          tick, frame_start, xfer, c_bit, par, bit_val, inv, pre_bit;
  logic [23:0]   cur;
  logic [4:0]    bit_idx;
  logic [7:0]    pre_pat;
  logic [2:0]    p_idx;

  always_comb begin
    tick        = (div_q == DIV_MAX);
    frame_start = tick & ~ui_q & (slot_q == 5'd0) & ~sub_q;
    xfer        = sample_valid & ready_q;
    cur         = sub_q ? tx_r_q : tx_l_q;
    bit_idx     = slot_q - 5'd4;
`ifdef TOI2S_SPDIF_CS_EN
    c_bit = (frame_q == 8'd2) |
            ((frame_q >= 8'd24) && (frame_q <= 8'd27) && CS_FS[frame_q[1:0]]);
`else
    c_bit = 1'b0;
`endif
    // U is always 0, so parity over 4..30 reduces to data, V and C
    par = (^cur) ^ tx_v_q ^ c_bit;
    if (slot_q < 5'd28) begin
      bit_val = cur[bit_idx];
    end else begin
      case (slot_q[1:0])
        2'd0:    bit_val = tx_v_q;
        2'd1:    bit_val = 1'b0;
        2'd2:    bit_val = c_bit;
        default: bit_val = par;
      endcase
    end
    pre_pat = sub_q ? 8'b11100100 : ((frame_q == 8'd0) ? 8'b11101000 : 8'b11100010);
    p_idx   = {slot_q[1:0], ui_q};
    pre_bit = pre_pat[3'd7 - p_idx];
    // preamble polarity is fixed by the line level just before its first UI
    inv     = (p_idx == 3'd0) ? tx_out_q : pre_inv_q;
  end

  always_comb begin
    div_d     = tick ? '0 : div_q + CW'(1);
    ui_d      = ui_q;
    slot_d    = slot_q;
    sub_d     = sub_q;
    frame_d   = frame_q;
    full_d    = full_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    tx_l_d    = tx_l_q;
    tx_r_d    = tx_r_q;
    tx_v_d    = tx_v_q;
    pre_inv_d = pre_inv_q;
    tx_out_d  = tx_out_q;
    bs_d      = 1'b0;
    ur_d      = 1'b0;

    if (xfer) begin
      hold_l_d = sample_l;
      hold_r_d = sample_r;
      full_d   = 1'b1;
    end

    if (tick) begin
      if (slot_q < 5'd4) begin
        tx_out_d  = pre_bit ^ inv;
        pre_inv_d = inv;
      end else if (!ui_q) begin
        tx_out_d = ~tx_out_q;
      end else begin
        tx_out_d = tx_out_q ^ bit_val;
      end

      ui_d = ~ui_q;
      if (ui_q) begin
        slot_d = slot_q + 5'd1;
        if (slot_q == 5'd31) begin
          sub_d = ~sub_q;
          if (sub_q) frame_d = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
        end
      end

      if (frame_start) begin
        bs_d = (frame_q == 8'd0);
        if (full_q) begin
          tx_l_d = hold_l_q;
          tx_r_d = hold_r_q;
          tx_v_d = 1'b0;
          full_d = 1'b0;
        end else if (xfer) begin
          tx_l_d = sample_l;
          tx_r_d = sample_r;
          tx_v_d = 1'b0;
          full_d = 1'b0;
        end else begin
          tx_l_d = '0;
          tx_r_d = '0;
          tx_v_d = 1'b1;
          ur_d   = 1'b1;
        end
      end
    end

    if (!ena) begin
      div_d     = '0;
      ui_d      = 1'b0;
      slot_d    = '0;
      sub_d     = 1'b0;
      frame_d   = '0;
      full_d    = 1'b0;
      pre_inv_d = 1'b0;
      tx_out_d  = 1'b0;
      bs_d      = 1'b0;
      ur_d      = 1'b0;
    end

    ready_d = ena & ~full_d;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      div_q     <= '0;
      ui_q      <= 1'b0;
      slot_q    <= '0;
      sub_q     <= 1'b0;
      frame_q   <= '0;
      full_q    <= 1'b0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      tx_l_q    <= '0;
      tx_r_q    <= '0;
      tx_v_q    <= 1'b0;
      pre_inv_q <= 1'b0;
      tx_out_q  <= 1'b0;
      ready_q   <= 1'b0;
      bs_q      <= 1'b0;
      ur_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      ui_q      <= ui_d;
      slot_q    <= slot_d;
      sub_q     <= sub_d;
      frame_q   <= frame_d;
      full_q    <= full_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      tx_l_q    <= tx_l_d;
      tx_r_q    <= tx_r_d;
      tx_v_q    <= tx_v_d;
      pre_inv_q <= pre_inv_d;
      tx_out_q  <= tx_out_d;
      ready_q   <= ready_d;
      bs_q      <= bs_d;
      ur_q      <= ur_d;
    end
  end

  assign sample_ready = ready_q;
  assign tx_out       = tx_out_q;
  assign block_start  = bs_q;
  assign underrun     = ur_q;
endmodule

// File: tb/tb_toi2s_spdif_tx.sv
// Bench for toi2s_spdif_tx: decodes tx_out back into subframes and checks them against a
// scoreboard of expected subframes pushed as pairs are offered (or withheld).
module tb_toi2s_spdif_tx;
  localparam int         UI_DIV   = 2;
  localparam logic [3:0] TB_CS_FS = 4'b0010;

  typedef struct packed {
    logic [1:0]  pre;   // 0=B 1=M 2=W 3=invalid
    logic [23:0] dat;
    logic        v;
    logic        u;
    logic        c;
    logic        p;
    logic        bad;   // biphase or UI-length violation
  } sf_t;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        ena = 1'b0;
  logic [23:0] sample_l = '0;
  logic [23:0] sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, tx_out, block_start, underrun;

  toi2s_spdif_tx #(.UI_DIV(UI_DIV), .CS_FS(TB_CS_FS)) dut (
    .clk(clk), .resetb(resetb), .ena(ena),
    .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .tx_out(tx_out),
    .block_start(block_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  int     n_cmp = 0;
  int     n_bad = 0;
  sf_t    exp_q[$];
  sf_t    obs_q[$];
  int     bs_cnt = 0;
  int     ur_cnt = 0;
  int     to_cnt = 0;
  int     lat = 0;
  longint bs_t[$];
  longint cyc = 0;

  // ---------------- expected-value model ----------------
  function automatic logic cs_bit(input int f);
`ifdef TOI2S_SPDIF_CS_EN
    logic [3:0] fs;
    fs = TB_CS_FS;
    return (f == 2) || (f >= 24 && f <= 27 && fs[f-24]);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void push_frame(input int f, input logic [23:0] l, input logic [23:0] r,
                                     input logic v);
    sf_t e;
    logic c;
    c     = cs_bit(f % 192);
    e.pre = (f % 192 == 0) ? 2'd0 : 2'd1;
    e.dat = l; e.v = v; e.u = 1'b0; e.c = c; e.p = (^l) ^ v ^ c; e.bad = 1'b0;
    exp_q.push_back(e);
    e.pre = 2'd2; e.dat = r; e.p = (^r) ^ v ^ c;
    exp_q.push_back(e);
  endfunction

  function automatic string fmt(input sf_t s);
    return $sformatf("pre=%0d dat=%h v=%b u=%b c=%b p=%b bad=%b",
                     s.pre, s.dat, s.v, s.u, s.c, s.p, s.bad);
  endfunction

  // ---------------- line decoder ----------------
  logic [63:0] lvl;
  int          ph, ui_i;
  logic        synced = 1'b0;
  logic        prev_lvl, bad_f;
  logic [7:0]  mon_pat;
  logic [27:0] mon_bits;
  sf_t         mon_o;

  always @(negedge clk) begin
    cyc++;
    if (block_start) begin bs_cnt++; bs_t.push_back(cyc); end
    if (underrun) ur_cnt++;
    if (!resetb || !ena) begin
      synced = 1'b0;
    end else begin
      if (block_start) begin
        if (!synced) begin
          synced = 1'b1; ui_i = 0; ph = 0; prev_lvl = 1'b0; bad_f = 1'b0;
        end else if (ui_i != 0 || ph != 0) begin
          bad_f = 1'b1;
        end
      end
      if (synced) begin
        if (ph == 0) lvl[ui_i] = tx_out;
        else if (tx_out !== lvl[ui_i]) bad_f = 1'b1;
        ph++;
        if (ph == UI_DIV) begin
          ph = 0;
          ui_i++;
          if (ui_i == 64) begin
            for (int k = 0; k < 8; k++) mon_pat[7-k] = lvl[k] ^ prev_lvl;
            for (int s = 4; s < 32; s++) begin
              if (lvl[2*s] == lvl[2*s-1]) bad_f = 1'b1;
              mon_bits[s-4] = lvl[2*s] ^ lvl[2*s+1];
            end
            mon_o.pre = (mon_pat == 8'hE8) ? 2'd0 : (mon_pat == 8'hE2) ? 2'd1 :
                        (mon_pat == 8'hE4) ? 2'd2 : 2'd3;
            mon_o.dat = mon_bits[23:0];
            mon_o.v   = mon_bits[24];
            mon_o.u   = mon_bits[25];
            mon_o.c   = mon_bits[26];
            mon_o.p   = mon_bits[27];
            mon_o.bad = bad_f;
            obs_q.push_back(mon_o);
            prev_lvl = lvl[63];
            ui_i     = 0;
            bad_f    = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    resetb = 1'b0; ena = 1'b0; sample_valid = 1'b0; sample_l = '0; sample_r = '0;
    repeat (3) @(negedge clk);
    obs_q.delete(); exp_q.delete(); bs_t.delete();
    bs_cnt = 0; ur_cnt = 0; to_cnt = 0;
    resetb = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
    int t;
    t = 0;
    sample_l = l; sample_r = r; sample_valid = 1'b1;
    while (!sample_ready && t < 4000) begin @(negedge clk); t++; end
    if (t >= 4000) to_cnt++;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int lim);
    int t;
    t = 0;
    while (obs_q.size() < n && t < lim) begin @(negedge clk); t++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int viol;
    resetb = 1'b0; ena = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx_out !== 1'b0)       begin n_bad++; $display("FAIL rst_tx_out: got %b want 0", tx_out); end
    n_cmp++; if (sample_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", sample_ready); end
    n_cmp++; if (block_start !== 1'b0)  begin n_bad++; $display("FAIL rst_block_start: got %b want 0", block_start); end
    n_cmp++; if (underrun !== 1'b0)     begin n_bad++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    resetb = 1'b1;
    viol = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_out !== 1'b0 || sample_ready !== 1'b0 || block_start !== 1'b0 || underrun !== 1'b0) viol++;
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL idle_quiet: %0d active cycles with ena=0, want 0", viol); end
  endtask

  task automatic test_single_frame();
    sf_t e, o;
    do_reset();
    ena = 1'b1; lat = 0;
    push_frame(0, 24'h000001, 24'h800000, 1'b0);
    fork
      send_pair(24'h000001, 24'h800000);
      for (int i = 1; i <= 4*UI_DIV; i++) begin
        @(negedge clk);
        if (block_start && lat == 0) lat = i;
      end
    join
    n_cmp++; if (lat !== UI_DIV) begin n_bad++; $display("FAIL single_bs_latency: got %0d want %0d", lat, UI_DIV); end
    n_cmp++; if (to_cnt !== 0) begin n_bad++; $display("FAIL single_handshake: %0d timeouts want 0", to_cnt); end
    n_cmp++; if (ur_cnt !== 0) begin n_bad++; $display("FAIL single_no_underrun: got %0d pulses want 0", ur_cnt); end
    wait_obs(2, 64*2*UI_DIV + 200);
    n_cmp++; if (obs_q.size() < 2) begin n_bad++; $display("FAIL single_obs_count: got %0d want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL single_subframe: got %s want %s", fmt(o), fmt(e)); end
    end
    n_cmp++; if (bs_cnt !== 1) begin n_bad++; $display("FAIL single_bs_count: got %0d want 1", bs_cnt); end
  endtask

  task automatic test_stream();
    localparam int NF = 200;
    sf_t e, o;
    logic [23:0] l, r;
    int idx;
    longint per;
    do_reset();
    ena = 1'b1;
    for (int k = 0; k < NF; k++) begin
      l = 24'($urandom()); r = 24'($urandom());
      push_frame(k, l, r, 1'b0);
      send_pair(l, r);
    end
    n_cmp++; if (ur_cnt !== 0) begin n_bad++; $display("FAIL stream_underrun: got %0d pulses want 0", ur_cnt); end
    n_cmp++; if (to_cnt !== 0) begin n_bad++; $display("FAIL stream_handshake: %0d timeouts want 0", to_cnt); end
    wait_obs(2*NF, 2*64*2*UI_DIV + 1000);
    n_cmp++; if (obs_q.size() < 2*NF) begin n_bad++; $display("FAIL stream_obs_count: got %0d want %0d", obs_q.size(), 2*NF); end
    idx = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL stream_subframe%0d: got %s want %s", idx, fmt(o), fmt(e)); end
      idx++;
    end
    n_cmp++; if (bs_cnt !== 2) begin n_bad++; $display("FAIL stream_bs_count: got %0d want 2", bs_cnt); end
    per = (bs_t.size() >= 2) ? bs_t[1] - bs_t[0] : 0;
    n_cmp++; if (per !== longint'(192*128*UI_DIV)) begin n_bad++; $display("FAIL stream_bs_period: got %0d want %0d", per, 192*128*UI_DIV); end
  endtask

  task automatic test_underrun();
    sf_t e, o;
    logic [23:0] l, r;
    int t;
    do_reset();
    ena = 1'b1;
    for (int k = 0; k < 5; k++) begin
      l = 24'($urandom()); r = 24'($urandom());
      push_frame(k, l, r, 1'b0);
      send_pair(l, r);
    end
    push_frame(5, 24'h0, 24'h0, 1'b1);
    push_frame(6, 24'h0, 24'h0, 1'b1);
    t = 0;
    while (ur_cnt < 2 && t < 4*128*UI_DIV) begin @(negedge clk); t++; end
    n_cmp++; if (ur_cnt !== 2) begin n_bad++; $display("FAIL ur_pulses: got %0d want 2", ur_cnt); end
    l = 24'h7E5A01; r = 24'h00FF00;
    push_frame(7, l, r, 1'b0);
    send_pair(l, r);
    wait_obs(14, 3*128*UI_DIV);
    repeat (10) @(negedge clk);
    n_cmp++; if (ur_cnt !== 2) begin n_bad++; $display("FAIL ur_resume: got %0d pulses want 2", ur_cnt); end
    wait_obs(16, 2*128*UI_DIV);
    n_cmp++; if (obs_q.size() < 16) begin n_bad++; $display("FAIL ur_obs_count: got %0d want 16", obs_q.size()); end
    t = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL ur_subframe%0d: got %s want %s", t, fmt(o), fmt(e)); end
      t++;
    end
    n_cmp++; if (sample_ready !== 1'b1) begin n_bad++; $display("FAIL ur_ready_before_rst: got %b want 1", sample_ready); end
    resetb = 1'b0;
    #1;
    n_cmp++; if (sample_ready !== 1'b0 || tx_out !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: ready=%b tx_out=%b want 0 0", sample_ready, tx_out);
    end
  endtask

  task automatic test_mid_disable();
    sf_t e, o;
    logic [23:0] l, r;
    logic rdy1;
    int t, viol;
    do_reset();
    ena = 1'b1; sample_l = 24'h123456; sample_r = 24'hABCDEF; sample_valid = 1'b1;
    t = 0;
    while (!block_start && t < 100) begin @(negedge clk); t++; end
    n_cmp++; if (t >= 100) begin n_bad++; $display("FAIL mid_sync: no block_start in %0d cycles, want one", t); end
    repeat (98*UI_DIV) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx_out !== 1'b0) begin n_bad++; $display("FAIL mid_tx_off: got %b want 0", tx_out); end
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_out !== 1'b0 || sample_ready !== 1'b0 || block_start !== 1'b0 || underrun !== 1'b0) viol++;
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL mid_held_idle: %0d active cycles want 0", viol); end
    obs_q.delete(); exp_q.delete(); bs_t.delete(); bs_cnt = 0; ur_cnt = 0;
    l = 24'h5A5A5A; r = 24'h0F0F0F;
    sample_l = l; sample_r = r; sample_valid = 1'b1; ena = 1'b1;
    push_frame(0, l, r, 1'b0);
    lat = 0; rdy1 = 1'b0;
    for (int i = 1; i <= 4*UI_DIV; i++) begin
      @(negedge clk);
      if (i == 1) rdy1 = sample_ready;
      if (block_start && lat == 0) lat = i;
    end
    n_cmp++; if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL mid_ready_rise: got %b want 1", rdy1); end
    n_cmp++; if (lat !== UI_DIV) begin n_bad++; $display("FAIL mid_bs_latency: got %0d want %0d", lat, UI_DIV); end
    wait_obs(2, 64*2*UI_DIV + 200);
    n_cmp++; if (obs_q.size() < 2) begin n_bad++; $display("FAIL mid_obs_count: got %0d want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL mid_subframe: got %s want %s", fmt(o), fmt(e)); end
    end
    n_cmp++; if (bs_cnt !== 1) begin n_bad++; $display("FAIL mid_bs_count: got %0d want 1", bs_cnt); end
    sample_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_stream();
    test_underrun();
    test_mid_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/toi2s_spdif_tx.md
# toi2s_spdif_tx

S/PDIF (IEC 60958) biphase-mark transmitter for the toi2s design; it is the transmit end of the optical/coax link that the toi2s receiver path decodes. The block accepts 24-bit stereo sample pairs over a valid/ready handshake and frames them into subframes with preambles, V/U/C/P bits and biphase-mark coding on a single serial output. Typical uses are loopback test of the receiver on the FPGA build and a digital audio output from the chip.

## Interface
- UI_DIV, 4, clk cycles per unit interval (half bit cell); legal values are ≥ 2. With a 24.576 MHz clk, 4 gives 48 kHz.
- CS_FS, 4'b0100, channel-status sampling-frequency code, placed in CS bits 24..27 (LSB at bit 24).
- clk  in  1  system clock.
- resetb  in  1  reset. Asynchronous, active-low.
- ena  in  1  transmit enable. When low, the block is held idle.
- sample_l  in  24  left sample, two's complement.
- sample_r  in  24  right sample, two's complement.
- sample_valid  in  1  the sample pair is valid.
- sample_ready  out  1  the holding register is empty. A transfer occurs when valid & ready.
- tx_out  out  1  biphase-mark serial output (registered).
- block_start  out  1  one-cycle pulse when frame 0 (B preamble) of a 192-frame block begins.
- underrun  out  1  one-cycle pulse when a frame starts with no sample pair available.

## Operation
- UI tick: a counter runs 0..UI_DIV-1 and ticks at wrap. All line-state changes occur on ticks only.
- Frame structure:
  - frame = left subframe + right subframe.
  - subframe = 32 slots × 2 UI = 64 UI.
  - block = 192 frames.
  - Counters: ui_in_slot (0..1), slot (0..31), sub (0..1), frame (0..191). All wrap to 0.
- Slot map:
  - 0-3: preamble (8 UI).
  - 4-27: audio, LSB first.
  - 28: V.
  - 29: U = 0.
  - 30: C.
  - 31: P. Even parity over slots 4..31, so each subframe carries an even number of ones in 4..31.
- Preambles, MSB first, for a line level of 0 at the end of the previous UI:
  - B = 11101000, used for sub 0 of frame 0.
  - M = 11100010, used for sub 0 of other frames.
  - W = 11100100, used for sub 1.
  - If the previous level is 1, the complement is emitted.
  - Preambles are sent raw, without biphase coding.
- Biphase mark coding for slots 4..31:
  - First UI of each slot: tx_out toggles.
  - Second UI: tx_out toggles iff the bit is 1.
- Buffering: one holding register (48 bits plus a full flag).
  - sample_ready = ~full & ena.
  - At frame start (the tick beginning slot 0 of sub 0), the holding register moves to the transmit pair and full clears.
  - If the holding register is empty at frame start and no transfer is occurring that cycle, the block sends zeros with V=1 in both subframes and pulses underrun. Otherwise V=0.
  - Simultaneous transfer and frame start with the holding register empty: the incoming pair is bypassed directly into the transmit pair. This is not an underrun, and full stays 0.
- ena low:
  - tx_out is forced to 0.
  - All counters clear to frame 0 / sub 0 / slot 0, and full clears.
  - Outputs follow on the next cycle.
  - The first frame after ena rises is a B frame, and block_start pulses on it.

## Timing
- Reset values: tx_out=0, sample_ready=0, block_start=0, underrun=0. All counters and the full flag are 0.
- sample_ready is registered. It rises 1 cycle after reset release with ena=1, and 1 cycle after the frame-start load.
- tx_out changes one clk after the tick cycle that selects the new UI level.
- block_start and underrun are asserted in the cycle after the frame-start tick, for exactly 1 cycle.
- Latency: a pair accepted before frame start N is transmitted in frame N. Its first preamble UI appears on tx_out 1 clk after the frame-start tick.
- Reset mid-frame: immediate return to reset values. No partial subframe is completed.

## Configuration
- TOI2S_SPDIF_CS_EN defined:
  - The C bit carries consumer channel-status bit n = frame index, with the same bit in both subframes.
  - Bit 2 = 1 (copy permitted).
  - Bits 24..27 = CS_FS.
  - All other bits = 0.
- TOI2S_SPDIF_CS_EN undefined: C = 0 in every subframe and the CS logic is absent. Parity still covers C.

## Test plan
- Idle: resetb low, then ena=0 for 1000 cycles -> tx_out=0, sample_ready=0, no pulses.
- Single frame: UI_DIV=4, ena=1, one pair L=24'h000001, R=24'h800000 -> decoded sub 0 = B, data 1, V=0, P=1; sub 1 = W, data 0x800000, P=1. Each UI lasts 4 cycles, and block_start pulses once.
- Continuous stream: a new pair every frame for 384 frames -> no underrun, B preamble only at frames 0 and 192, block_start period 192×128×4 cycles, every subframe has even parity.
- Underrun: withhold valid for frames 5-6, then resume -> underrun pulses twice, those frames carry 0 data with V=1, frame 7 carries the resumed data with V=0.
- Channel status: 192 frames with CS_FS=4'b0010 -> with TOI2S_SPDIF_CS_EN, collected C bits are 1 at indices 2 and 25 only; without it, all C bits are 0.
- Mid-frame disable: drop ena at slot 17 of sub 1 -> tx_out=0 on the next cycle. Re-enable with valid held -> the first preamble is B, block_start pulses, and sample_ready rises 1 cycle after ena.
